// File: rtl/qbert_move_ctrl.sv
// qbert_move_ctrl -- jump-command initiator for the Q*bert pyramid.
//
// Turns the four direction buttons into a jump code plus a one-hot target
// cube for the display layer. Each move is committed only after the layer's
// done_move_qb busy/idle handshake. Also tracks visited cubes and flags the win.
//
// Optional feature macro: QBERT_MOVE_BUFFER_EN
//   When defined, the first press seen while a jump is in flight is stored.
//   It is issued right after a successful commit.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-low reset
//   btn_dr/dl/ur/ul direction buttons (synchronised levels)
//   e_restart      pulse: back to cube 1, clear visited map
//   e_respawn      pulse: leave FALLEN, back to cube 1
//   done_move_qb   display layer idle (1) / jump in progress (0)
//   e_jump_qb      jump code 0 none, 1 DR, 2 DL, 3 UR, 4 UL
//   position_qb    one-hot current cube (0 = off pyramid)
//   e_next_qb      one-hot target cube (0 = off pyramid)
//   visited        visited map, bit k-1 = cube k
//   cubes_left     unvisited cube count
//   e_win_qb       one-cycle pulse when cubes_left reaches 0
//   move_state     FSM state encoding for readback
module qbert_move_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_dr,
    input  logic        btn_dl,
    input  logic        btn_ur,
    input  logic        btn_ul,
    input  logic        e_restart,
    input  logic        e_respawn,
    input  logic        done_move_qb,
    output logic [2:0]  e_jump_qb,
    output logic [27:0] position_qb,
    output logic [27:0] e_next_qb,
    output logic [27:0] visited,
    output logic [4:0]  cubes_left,
    output logic        e_win_qb,
    output logic [2:0]  move_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_MOVING = 3'd2,
        S_COMMIT = 3'd3,
        S_FALLEN = 3'd4
    } state_t;

    // Cube location; on=0 means off the pyramid (row/col then meaningless).
    typedef struct packed {
        logic       on;
        logic [2:0] r;
        logic [2:0] c;
    } cell_t;

    localparam cell_t TOP_CUBE = '{on: 1'b1, r: 3'd1, c: 3'd1};
    localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

    // Zero-based cube index: r(r-1)/2 + c - 1.
    function automatic logic [4:0] cube_idx(input logic [2:0] r, input logic [2:0] c);
        logic [4:0] base;
        case (r)
            3'd2:    base = 5'd1;
            3'd3:    base = 5'd3;
            3'd4:    base = 5'd6;
            3'd5:    base = 5'd10;
            3'd6:    base = 5'd15;
            3'd7:    base = 5'd21;
            default: base = 5'd0;
        endcase
        return base + {2'b00, c} - 5'd1;
    endfunction

    function automatic logic [27:0] cube_onehot(input cell_t p);
        return p.on ? (28'd1 << cube_idx(p.r, p.c)) : 28'd0;
    endfunction

    // Widened to 4 bits so row 8 and row/col 0 are representable before the
    // on-pyramid test.
    function automatic cell_t jump_target(input cell_t from, input logic [2:0] code);
        logic [3:0] r;
        logic [3:0] c;
        cell_t      t;
        r = {1'b0, from.r};
        c = {1'b0, from.c};
        case (code)
            3'd1:    r = r + 4'd1;
            3'd2:    begin r = r + 4'd1; c = c + 4'd1; end
            3'd3:    begin r = r - 4'd1; c = c - 4'd1; end
            3'd4:    r = r - 4'd1;
            default: ;
        endcase
        t.on = from.on && (r >= 4'd1) && (r <= 4'd7) && (c >= 4'd1) && (c <= r);
        t.r  = r[2:0];
        t.c  = c[2:0];
        return t;
    endfunction

    state_t      state, state_nxt;
    cell_t       pos, pos_nxt;
    cell_t       tgt, tgt_nxt;
    logic [2:0]  jump_nxt;
    logic [27:0] position_nxt, next_nxt, visited_nxt;
    logic [4:0]  left_nxt;
    logic        win_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [3:0]  btn_q;
    logic        armed;
    logic [3:0]  btn_now, rise;
    logic [2:0]  press_code, issue_code;
    logic [4:0]  land_idx;

`ifdef QBERT_MOVE_BUFFER_EN
    logic        buf_vld, buf_vld_nxt;
    logic [2:0]  buf_code, buf_code_nxt;
`endif

    assign btn_now    = {btn_ul, btn_ur, btn_dl, btn_dr};
    // armed masks the first cycle after reset so a held button is not a press.
    assign rise       = armed ? (btn_now & ~btn_q) : 4'd0;
    assign press_code = rise[0] ? 3'd1 :
                        rise[1] ? 3'd2 :
                        rise[2] ? 3'd3 :
                        rise[3] ? 3'd4 : 3'd0;
    assign land_idx   = cube_idx(tgt.r, tgt.c);
    assign move_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pos         <= TOP_CUBE;
            tgt         <= TOP_CUBE;
            e_jump_qb   <= 3'd0;
            position_qb <= 28'h1;
            e_next_qb   <= 28'h1;
            visited     <= 28'd0;
            cubes_left  <= 5'd28;
            e_win_qb    <= 1'b0;
            cnt         <= 16'd0;
            btn_q       <= 4'd0;
            armed       <= 1'b0;
`ifdef QBERT_MOVE_BUFFER_EN
            buf_vld     <= 1'b0;
            buf_code    <= 3'd0;
`endif
        end else begin
            state       <= state_nxt;
            pos         <= pos_nxt;
            tgt         <= tgt_nxt;
            e_jump_qb   <= jump_nxt;
            position_qb <= position_nxt;
            e_next_qb   <= next_nxt;
            visited     <= visited_nxt;
            cubes_left  <= left_nxt;
            e_win_qb    <= win_nxt;
            cnt         <= cnt_nxt;
            btn_q       <= btn_now;
            armed       <= 1'b1;
`ifdef QBERT_MOVE_BUFFER_EN
            buf_vld     <= buf_vld_nxt;
            buf_code    <= buf_code_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        pos_nxt      = pos;
        tgt_nxt      = tgt;
        jump_nxt     = e_jump_qb;
        position_nxt = position_qb;
        next_nxt     = e_next_qb;
        visited_nxt  = visited;
        left_nxt     = cubes_left;
        win_nxt      = 1'b0;
        cnt_nxt      = cnt;
        issue_code   = 3'd0;
`ifdef QBERT_MOVE_BUFFER_EN
        buf_vld_nxt  = buf_vld;
        buf_code_nxt = buf_code;
`endif

        if (e_restart) begin
            state_nxt    = S_IDLE;
            pos_nxt      = TOP_CUBE;
            tgt_nxt      = TOP_CUBE;
            jump_nxt     = 3'd0;
            position_nxt = 28'h1;
            next_nxt     = 28'h1;
            visited_nxt  = 28'd0;
            left_nxt     = 5'd28;
            cnt_nxt      = 16'd0;
`ifdef QBERT_MOVE_BUFFER_EN
            buf_vld_nxt  = 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (done_move_qb)
                        issue_code = press_code;
`ifdef QBERT_MOVE_BUFFER_EN
                    // A buffered press follows a commit straight away,
                    // without waiting for the layer to report idle.
                    if (buf_vld)
                        issue_code = buf_code;
                    buf_vld_nxt = 1'b0;
`endif
                    if (issue_code != 3'd0) begin
                        tgt_nxt   = jump_target(pos, issue_code);
                        jump_nxt  = issue_code;
                        next_nxt  = cube_onehot(tgt_nxt);
                        cnt_nxt   = 16'd0;
                        state_nxt = S_ISSUE;
                    end
                end

                S_ISSUE: begin
`ifdef QBERT_MOVE_BUFFER_EN
                    if (!buf_vld && press_code != 3'd0) begin
                        buf_vld_nxt  = 1'b1;
                        buf_code_nxt = press_code;
                    end
`endif
                    if (!done_move_qb) begin
                        state_nxt = S_MOVING;
                    end else if (cnt >= CNT_LAST) begin
                        // Layer never accepted: cancel, position unchanged.
                        jump_nxt  = 3'd0;
                        next_nxt  = position_qb;
                        state_nxt = S_IDLE;
`ifdef QBERT_MOVE_BUFFER_EN
                        buf_vld_nxt = 1'b0;
`endif
                    end else if (cnt != 16'hFFFF) begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end

                S_MOVING: begin
`ifdef QBERT_MOVE_BUFFER_EN
                    if (!buf_vld && press_code != 3'd0) begin
                        buf_vld_nxt  = 1'b1;
                        buf_code_nxt = press_code;
                    end
`endif
                    if (done_move_qb)
                        state_nxt = S_COMMIT;
                end

                S_COMMIT: begin
                    pos_nxt      = tgt;
                    jump_nxt     = 3'd0;
                    position_nxt = cube_onehot(tgt);
                    next_nxt     = cube_onehot(tgt);
                    if (!tgt.on) begin
                        state_nxt = S_FALLEN;
`ifdef QBERT_MOVE_BUFFER_EN
                        buf_vld_nxt = 1'b0;
`endif
                    end else begin
                        state_nxt = S_IDLE;
                        if (!visited[land_idx]) begin
                            visited_nxt[land_idx] = 1'b1;
                            left_nxt = cubes_left - 5'd1;
                            win_nxt  = (cubes_left == 5'd1);
                        end
                    end
                end

                S_FALLEN: begin
                    if (e_respawn) begin
                        pos_nxt      = TOP_CUBE;
                        position_nxt = 28'h1;
                        next_nxt     = 28'h1;
                        state_nxt    = S_IDLE;
                    end
                end

                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Scoreboard bench for qbert_move_ctrl: the driver pushes expected issue and
// completion records, and a monitor checks them whenever e_jump_qb changes.
module tb_qbert_move_ctrl;

    localparam int TO = 1024;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_dr = 1'b0, btn_dl = 1'b0, btn_ur = 1'b0, btn_ul = 1'b0;
    logic e_restart = 1'b0, e_respawn = 1'b0, done_move_qb = 1'b1;
    logic [2:0]  e_jump_qb;
    logic [27:0] position_qb, e_next_qb, visited;
    logic [4:0]  cubes_left;
    logic        e_win_qb;
    logic [2:0]  move_state;

    qbert_move_ctrl #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .btn_dr(btn_dr), .btn_dl(btn_dl), .btn_ur(btn_ur), .btn_ul(btn_ul),
        .e_restart(e_restart), .e_respawn(e_respawn), .done_move_qb(done_move_qb),
        .e_jump_qb(e_jump_qb), .position_qb(position_qb), .e_next_qb(e_next_qb),
        .visited(visited), .cubes_left(cubes_left), .e_win_qb(e_win_qb),
        .move_state(move_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [2:0] code; logic [27:0] nxt; } iss_t;
    typedef struct { logic [27:0] pos; logic [27:0] vis; logic [4:0] left; logic win; } end_t;
    iss_t iss_q[$];
    end_t end_q[$];

    // Reference model: plain row/column coordinates and a visited bitmap.
    int      m_r = 1, m_c = 1;
    bit      m_on = 1'b1;
    int      t_r, t_c;
    bit      t_on;
    bit [27:0] m_vis = '0;
    int      m_left = 28;
    int      m_wins = 0;
    int      dut_wins = 0;

    function automatic int cube_num(int r, int c);
        return r * (r - 1) / 2 + c;
    endfunction

    function automatic bit on_pyr(int r, int c);
        return r >= 1 && r <= 7 && c >= 1 && c <= r;
    endfunction

    function automatic logic [27:0] oh(int r, int c, bit on);
        logic [27:0] v;
        v = '0;
        if (on) v[cube_num(r, c) - 1] = 1'b1;
        return v;
    endfunction

    task automatic target_of(input int code, input int r, input int c, output int nr, output int nc);
        nr = r; nc = c;
        case (code)
            1: nr = r + 1;
            2: begin nr = r + 1; nc = c + 1; end
            3: begin nr = r - 1; nc = c - 1; end
            4: nr = r - 1;
            default: ;
        endcase
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: reacts to e_jump_qb transitions only.
    logic [2:0]  mon_prev = 3'd0;
    logic [27:0] mon_next = '0;
    iss_t ei;
    end_t ee;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_prev = 3'd0;
            end else begin
                if (e_win_qb) dut_wins++;
                if (mon_prev == 3'd0 && e_jump_qb != 3'd0) begin
                    if (iss_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_issue: got code %0d expected none", e_jump_qb);
                    end else begin
                        ei = iss_q.pop_front();
                        check("issue_code", 64'(e_jump_qb), 64'(ei.code));
                        check("issue_next", 64'(e_next_qb), 64'(ei.nxt));
                    end
                    mon_next = e_next_qb;
                end else if (mon_prev != 3'd0 && e_jump_qb == 3'd0) begin
                    if (end_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_end: got position %0h expected none", position_qb);
                    end else begin
                        ee = end_q.pop_front();
                        check("end_position", 64'(position_qb), 64'(ee.pos));
                        check("end_visited", 64'(visited), 64'(ee.vis));
                        check("end_cubes_left", 64'(cubes_left), 64'(ee.left));
                        check("end_win", 64'(e_win_qb), 64'(ee.win));
                    end
                end else if (mon_prev != 3'd0) begin
                    check("hold_code", 64'(e_jump_qb), 64'(mon_prev));
                    check("hold_next", 64'(e_next_qb), 64'(mon_next));
                end
                mon_prev = e_jump_qb;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_btn(input bit [3:0] mask);
        {btn_ul, btn_ur, btn_dl, btn_dr} = mask;
        cyc(1);
        {btn_ul, btn_ur, btn_dl, btn_dr} = 4'd0;
    endtask

    task automatic expect_issue(input int code);
        target_of(code, m_r, m_c, t_r, t_c);
        t_on = on_pyr(t_r, t_c);
        iss_q.push_back('{code: 3'(code), nxt: oh(t_r, t_c, t_on)});
    endtask

    task automatic model_commit();
        end_t e;
        e.win = 1'b0;
        m_r = t_r; m_c = t_c; m_on = t_on;
        if (m_on && !m_vis[cube_num(m_r, m_c) - 1]) begin
            m_vis[cube_num(m_r, m_c) - 1] = 1'b1;
            m_left--;
            if (m_left == 0) begin e.win = 1'b1; m_wins++; end
        end
        e.pos = oh(m_r, m_c, m_on); e.vis = m_vis; e.left = 5'(m_left);
        end_q.push_back(e);
    endtask

    task automatic model_restart();
        m_r = 1; m_c = 1; m_on = 1'b1; m_vis = '0; m_left = 28;
    endtask

    task automatic do_restart();
        e_restart = 1'b1; cyc(1); e_restart = 1'b0; cyc(1);
        model_restart();
    endtask

    // One full move with handshake; respawns after a fall.
    task automatic do_move(input int code, input bit [3:0] mask);
        expect_issue(code);
        press_btn(mask);
        check("issue_latency", 64'(e_jump_qb), 64'(code));
        done_move_qb = 1'b0; cyc(2);
        done_move_qb = 1'b1;
        model_commit();
        cyc(4);
        check("idle_next", 64'(e_next_qb), 64'(oh(m_r, m_c, m_on)));
        if (!m_on) begin
            check("fallen_state", 64'(move_state), 64'd4);
            e_respawn = 1'b1; cyc(1); e_respawn = 1'b0; cyc(1);
            m_r = 1; m_c = 1; m_on = 1'b1;
            check("respawn_pos", 64'(position_qb), 64'h1);
        end
    endtask

    function automatic bit [3:0] mask_of(int code);
        return 4'(1 << (code - 1));
    endfunction

    task automatic greedy_step();
        int cand[$], pref[$];
        int nr, nc, pick;
        for (int code = 1; code <= 4; code++) begin
            target_of(code, m_r, m_c, nr, nc);
            if (on_pyr(nr, nc)) begin
                cand.push_back(code);
                if (!m_vis[cube_num(nr, nc) - 1]) pref.push_back(code);
            end
        end
        if (pref.size() != 0 && $urandom_range(0, 9) < 7)
            pick = pref[$urandom_range(0, pref.size() - 1)];
        else
            pick = cand[$urandom_range(0, cand.size() - 1)];
        do_move(pick, mask_of(pick));
    endtask

    initial begin
        int code;
        int moves;
        // Reset, with a button held through the release.
        btn_dr = 1'b1;
        cyc(3);
        check("rst_position", 64'(position_qb), 64'h1);
        check("rst_next", 64'(e_next_qb), 64'h1);
        check("rst_jump", 64'(e_jump_qb), 64'd0);
        check("rst_visited", 64'(visited), 64'd0);
        check("rst_cubes_left", 64'(cubes_left), 64'd28);
        check("rst_win", 64'(e_win_qb), 64'd0);
        check("rst_state", 64'(move_state), 64'd0);
        reset = 1'b1;
        cyc(3);
        check("held_btn_no_press", 64'(e_jump_qb), 64'd0);
        btn_dr = 1'b0;
        cyc(2);

        // DR handshake from the top cube.
        do_move(1, 4'b0001);
        check("dr_visited", 64'(visited), 64'h2);
        check("dr_cubes_left", 64'(cubes_left), 64'd27);

        // Fall off the right edge (UR from cube 2); presses ignored while fallen.
        expect_issue(3);
        press_btn(4'b0100);
        done_move_qb = 1'b0; cyc(2); done_move_qb = 1'b1;
        model_commit();
        cyc(4);
        check("fallen_pos", 64'(position_qb), 64'd0);
        check("fallen_state", 64'(move_state), 64'd4);
        press_btn(4'b0001);
        cyc(3);
        check("fallen_ignores", 64'(move_state), 64'd4);
        e_respawn = 1'b1; cyc(1); e_respawn = 1'b0; cyc(1);
        m_r = 1; m_c = 1; m_on = 1'b1;
        check("respawn_pos", 64'(position_qb), 64'h1);
        check("respawn_visited", 64'(visited), 64'h2);

        // Timeout: DL accepted, layer never goes busy.
        expect_issue(2);
        end_q.push_back('{pos: 28'h1, vis: m_vis, left: 5'(m_left), win: 1'b0});
        press_btn(4'b0010);
        cyc(TO - 8);
        check("timeout_still_issued", 64'(e_jump_qb), 64'd2);
        cyc(16);
        check("timeout_state", 64'(move_state), 64'd0);
        check("timeout_pos", 64'(position_qb), 64'h1);

        // DR and UL rise together: DR wins.
        do_move(1, 4'b1001);
        do_move(4, 4'b1000);

        // Press while layer busy in IDLE is discarded.
        done_move_qb = 1'b0; cyc(1);
        press_btn(4'b0001); cyc(2);
        done_move_qb = 1'b1; cyc(2);
        check("busy_press_dropped", 64'(e_jump_qb), 64'd0);

        // Restart during MOVING.
        expect_issue(2);
        press_btn(4'b0010);
        done_move_qb = 1'b0; cyc(2);
        model_restart();
        end_q.push_back('{pos: 28'h1, vis: 28'd0, left: 5'd28, win: 1'b0});
        e_restart = 1'b1; cyc(1); e_restart = 1'b0;
        check("restart_jump", 64'(e_jump_qb), 64'd0);
        check("restart_pos", 64'(position_qb), 64'h1);
        check("restart_visited", 64'(visited), 64'd0);
        done_move_qb = 1'b1; cyc(3);

        // Restart and press in the same cycle: press dropped.
        btn_dl = 1'b1; e_restart = 1'b1; cyc(1);
        btn_dl = 1'b0; e_restart = 1'b0; cyc(3);
        check("restart_beats_press", 64'(e_jump_qb), 64'd0);

        // Press during MOVING from cube 1.
        expect_issue(1);
        press_btn(4'b0001);
        done_move_qb = 1'b0; cyc(2);
        press_btn(4'b0010);
        cyc(1);
        done_move_qb = 1'b1;
        model_commit();
`ifdef QBERT_MOVE_BUFFER_EN
        expect_issue(2);
        cyc(4);
        check("buffer_issue", 64'(e_jump_qb), 64'd2);
        check("buffer_next", 64'(e_next_qb), 64'h10);
        done_move_qb = 1'b0; cyc(2); done_move_qb = 1'b1;
        model_commit();
        cyc(4);
`else
        cyc(4);
        check("no_buffer_issue", 64'(e_jump_qb), 64'd0);
`endif
        check("after_buffer_pos", 64'(position_qb), 64'(oh(m_r, m_c, m_on)));

        // Random walk including falls, then a biased walk to the win.
        do_restart();
        for (int i = 0; i < 30; i++) begin
            code = int'($urandom_range(1, 4));
            do_move(code, mask_of(code));
        end
        moves = 0;
        while (m_left > 0 && moves < 1500) begin
            greedy_step();
            moves++;
        end
        check("win_reached", 64'(cubes_left), 64'd0);
        for (int i = 0; i < 6; i++) greedy_step();
        check("cubes_left_after_revisits", 64'(cubes_left), 64'd0);
        check("win_pulses", 64'(dut_wins), 64'(m_wins));
        check("model_won_once", 64'(dut_wins), 64'd1);
        check("iss_q_drained", 64'(iss_q.size()), 64'd0);
        check("end_q_drained", 64'(end_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qbert_move_ctrl.md
# qbert_move_ctrl

Jump-command initiator for the Q*bert pyramid. It turns four direction buttons into the `e_jump_qb` / `e_next_qb` / `position_qb` command set consumed by the Q*bert display layer. It waits for that layer's `done_move_qb` handshake before committing each move. It also tracks which of the 28 cubes have been visited and flags the win.

## Interface
- `ACK_TIMEOUT`, 1024: cycles to wait in ISSUE for the layer to accept a jump before cancelling it (1..65535).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `btn_dr`, `btn_dl`, `btn_ur`, `btn_ul` in 1 each: direction buttons, level inputs, already synchronised.
- `e_restart` in 1: one-cycle pulse. Returns to the top cube and clears the visited map.
- `e_respawn` in 1: one-cycle pulse. Leaves the FALLEN state.
- `done_move_qb` in 1: from the display layer. High means the layer is idle; low means a jump is in progress.
- `e_jump_qb` out 3: jump code. 0 = none, 1 = DOWN_RIGHT, 2 = DOWN_LEFT, 3 = UP_RIGHT, 4 = UP_LEFT.
- `position_qb` out 28: one-hot current cube. Bit k-1 represents cube k. All zeros means off the pyramid.
- `e_next_qb` out 28: one-hot target cube. All zeros means the target is off the pyramid.
- `visited` out 28: one bit per cube visited.
- `cubes_left` out 5: number of unvisited cubes.
- `e_win_qb` out 1: one-cycle pulse when `cubes_left` reaches 0.
- `move_state` out 3: FSM state encoding, for NIOS readback.

## Operation
- Cube k sits at row r (1..7) and column c (1..r), with k = r(r-1)/2 + c. Cube 1 is the top. Column 1 is the right edge (cubes 2, 4, 7, 11, 16, 22). Column r is the left edge (cubes 3, 6, 10, 15, 21, 28).
- Internal position is held as a 3-bit row and 3-bit column. The one-hot outputs are decoded from these registers.
- Target for each jump code:
  - DR goes to (r+1, c).
  - DL goes to (r+1, c+1).
  - UR goes to (r-1, c-1).
  - UL goes to (r-1, c).
  - If the result has r > 7, r < 1, c < 1 or c > r, the target is off-pyramid and `e_next_qb` = 0.
- Button press = rising edge (current high, previous-cycle low). Priority when several rise in the same cycle: DR > DL > UR > UL.
- **IDLE:** `e_jump_qb` = 0 and `e_next_qb` = `position_qb`.
  - A press is accepted only when `done_move_qb` = 1.
  - On an accepted press: load the code and target, then go to ISSUE.
  - A press while `done_move_qb` = 0 is discarded.
- **ISSUE:** hold the code and target.
  - `done_move_qb` = 0 → MOVING.
  - Timeout counter reaches `ACK_TIMEOUT` → clear `e_jump_qb`, go to IDLE, position unchanged.
- **MOVING:** hold the outputs. `done_move_qb` = 1 → COMMIT.
- **COMMIT** (1 cycle):
  - Position takes the target and `e_jump_qb` is cleared to 0.
  - Off-pyramid target → FALLEN.
  - Otherwise set the visited bit for the new cube. If it was newly set, decrement `cubes_left`; if that makes it 0, pulse `e_win_qb`. Then go to IDLE.
- **FALLEN:** `position_qb` = 0 and presses are ignored. `e_respawn` → position = cube 1, go to IDLE. The visited map is kept.
- `e_restart` overrides everything, in any state:
  - position = cube 1, `visited` = 0, `cubes_left` = 28, `e_jump_qb` = 0.
  - Timeout counter and any buffered press are cleared.
  - Go to IDLE.
- The start cube is not marked visited. It becomes visited only when a jump lands on it.

## Timing
- All outputs are registered.
- Values during reset:
  - `position_qb` = 28'h1, `e_next_qb` = 28'h1, `e_jump_qb` = 0.
  - `visited` = 0, `cubes_left` = 28, `e_win_qb` = 0, state = IDLE.
  - Button edge registers are cleared, so a button held through reset release does not count as a press.
- Latency: press edge sampled at cycle n → `e_jump_qb` and `e_next_qb` valid at n+1.
- Commit: `done_move_qb` rises at cycle m in MOVING → COMMIT at m+1 → `position_qb` updated and `e_jump_qb` = 0 at m+2. `e_win_qb` is high during cycle m+2 only.
- `e_jump_qb` and `e_next_qb` are stable for the whole of ISSUE and MOVING, because the layer samples them only once.
- `e_restart` and a press edge in the same cycle: restart wins and the press is dropped.
- `e_respawn` outside FALLEN is ignored.
- The timeout counter resets on entry to ISSUE and saturates; it never wraps.

## Configuration
- `QBERT_MOVE_BUFFER_EN` defined: one-entry press buffer.
  - The first press edge seen during ISSUE or MOVING is stored; later presses are dropped.
  - After COMMIT to an on-pyramid cube, the buffered press is issued immediately: it goes straight to ISSUE with the target computed from the new position, skipping the `done_move_qb` = 1 check.
  - The buffer is cleared on FALLEN, on timeout, and on `e_restart`.
- Undefined: presses outside IDLE are discarded and no buffer logic is present.

## Test plan
- **Reset, then DR handshake:** release reset, pulse `btn_dr`, drive `done_move_qb` 1→0→1.
  - At n+1: `e_jump_qb` = 1, `e_next_qb` = 28'h2.
  - After commit: `position_qb` = 28'h2, `visited` = 28'h2, `cubes_left` = 27.
- **Fall off the right edge:** from cube 2, UR then handshake → `e_next_qb` = 0, then `position_qb` = 0 and FALLEN. Pulse `e_respawn` → `position_qb` = 28'h1.
- **Timeout:** press DL and hold `done_move_qb` = 1 for 1024 cycles → `e_jump_qb` returns to 0, `position_qb` unchanged, state IDLE.
- **Win:** visit all 28 cubes, checking exactly one `e_win_qb` pulse on the 28th commit and `cubes_left` = 0. Revisiting cube 5 causes no decrement.
- **Simultaneous events:** DR and UL rising in the same cycle → code 1 issued. `e_restart` during MOVING → `e_jump_qb` = 0, `position_qb` = 28'h1, `visited` = 0.
- **Buffer (`QBERT_MOVE_BUFFER_EN`):** press DL during MOVING from cube 1 → after commit to cube 2, `e_jump_qb` = 2 with `e_next_qb` = 28'h10 (cube 5) one cycle later.
